madd_seq_unit: RTL

- Multi-cycle multiply-accumulate unit for MADD/MADDU/MSUB/MSUBU in the EX stage.
- Produces the HI/LO write (hi, lo, whilo) that the EX/MEM pipeline register captures.
- Holds the pipeline through stallreq_o while it iterates.
- Replaces the two-pass hilo_temp/cnt feedback loop with a self-contained 32-step shift-add engine, plus a final accumulate step.

---
 rtl/madd_seq_unit.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/madd_seq_unit.sv
// Sequential MADD/MADDU/MSUB/MSUBU unit: 32-step shift-add multiply followed by
// one accumulate step into the forwarded {HI,LO}; holds EX via stallreq_o until DONE.
module madd_seq_unit #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [1:0]        op_i,
    input  logic [DATA_W-1:0] opdata1_i,
    input  logic [DATA_W-1:0] opdata2_i,
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    input  logic              annul_i,
    input  logic              stall_i,
    output logic              stallreq_o,
    output logic              ready_o,
    output logic [DATA_W-1:0] result_hi_o,
    output logic [DATA_W-1:0] result_lo_o,
    output logic              whilo_o
);

    localparam int PW = 2 * DATA_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ACC  = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        op_q, op_d;
    logic              neg_q, neg_d;
    logic [DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic [PW-1:0]     prod_q, prod_d;
    logic [PW-1:0]     res_q, res_d;
    logic              stallreq_s;
    logic              is_signed_s;
    logic [PW-1:0]     signed_prod_s;

    // Magnitude of an operand; the most-negative value maps onto itself, which is
    // the right unsigned magnitude.
    function automatic logic [DATA_W-1:0] abs_mag(input logic [DATA_W-1:0] v,
                                                   input logic is_signed);
        if (is_signed && v[DATA_W-1]) begin
            abs_mag = ~v + DATA_W'(1);
        end else begin
            abs_mag = v;
        end
    endfunction

    assign is_signed_s = ~op_i[0];

    // Next-state, datapath update and stall request
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        op_d          = op_q;
        neg_d         = neg_q;
        mcand_d       = mcand_q;
        mplier_d      = mplier_q;
        acc_d         = acc_q;
        prod_d        = prod_q;
        res_d         = res_q;
        stallreq_s    = 1'b0;
        signed_prod_s = neg_q ? (~prod_q + PW'(1)) : prod_q;

        if (annul_i) begin
            state_d = IDLE;
            cnt_d   = {CNT_W{1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    stallreq_s = start_i;
                    if (start_i) begin
                        op_d     = op_i;
                        acc_d    = {hi_i, lo_i};
                        mcand_d  = abs_mag(opdata1_i, is_signed_s);
                        mplier_d = abs_mag(opdata2_i, is_signed_s);
                        neg_d    = is_signed_s & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                        prod_d   = {PW{1'b0}};
                        cnt_d    = {CNT_W{1'b0}};
                        state_d  = MUL;
                    end else begin
                        state_d = IDLE;
                    end
                end
                MUL: begin
                    stallreq_s = 1'b1;
                    if (mplier_q[cnt_q]) begin
                        prod_d = prod_q + ({{DATA_W{1'b0}}, mcand_q} << cnt_q);
                    end else begin
                        prod_d = prod_q;
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_d = ACC;
                    end else begin
                        state_d = MUL;
                    end
                end
                ACC: begin
                    stallreq_s = 1'b1;
                    if (op_q[1]) begin
                        res_d = acc_q - signed_prod_s;
                    end else begin
                        res_d = acc_q + signed_prod_s;
                    end
                    state_d = DONE;
                end
                DONE: begin
                    // EX/MEM captures the result on the edge that leaves DONE
                    if (stall_i) begin
                        state_d = DONE;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            op_q     <= 2'b00;
            neg_q    <= 1'b0;
            mcand_q  <= {DATA_W{1'b0}};
            mplier_q <= {DATA_W{1'b0}};
            acc_q    <= {PW{1'b0}};
            prod_q   <= {PW{1'b0}};
            res_q    <= {PW{1'b0}};
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            prod_q   <= prod_d;
            res_q    <= res_d;
        end
    end

    // The stall request is gated by reset so every output is quiet while reset is held
    assign stallreq_o  = stallreq_s & rst;
    assign ready_o     = (state_q == DONE);
    assign whilo_o     = (state_q == DONE);
    assign result_hi_o = (state_q == DONE) ? res_q[PW-1:DATA_W] : {DATA_W{1'b0}};
    assign result_lo_o = (state_q == DONE) ? res_q[DATA_W-1:0]  : {DATA_W{1'b0}};

endmodule
